// File: rtl/image_frame_packetizer.sv
// image_frame_packetizer
// Frames the upstream payload byte stream into UART packets:
//   SYNC0, SYNC1, PAYLOAD_LEN[15:8], PAYLOAD_LEN[7:0], payload..., check byte.
// Paces the upstream producer to the Uart8 transmitter (one byte per UART byte).
// Optional macro PKT_CRC8_EN: check byte is CRC-8 (poly 0x07, init 0x00,
// MSB-first, no final XOR); otherwise the check byte is the payload sum mod 256.
module image_frame_packetizer #(
  parameter int unsigned PAYLOAD_LEN = 30,
  parameter logic [7:0]  SYNC0       = 8'hA5,
  parameter logic [7:0]  SYNC1       = 8'h5A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] tx_in,
  output logic       txEn,
  output logic       txStart,
  input  logic       txBusy,
  input  logic       txDone,
  output logic       frame_busy,
  output logic       frame_done
);

  localparam logic [15:0] LEN16   = 16'(PAYLOAD_LEN);
  // Index of the check byte; indices 4..CHK_IDX-1 are payload slots.
  localparam logic [16:0] CHK_IDX = 17'(PAYLOAD_LEN) + 17'd4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_SEND,
    PAY_WAIT,
    DONE
  } state_t;

  state_t      state, state_d;
  logic [16:0] idx, idx_d;
  logic [7:0]  chk, chk_d;
  logic [7:0]  tx_q, tx_d;

  // txDone is informational only; byte sequencing follows txBusy.
  logic unused_tx_done;
  assign unused_tx_done = txDone;

  // Fold one payload byte into the running check value.
  function automatic logic [7:0] chk_update(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
`ifdef PKT_CRC8_EN
    r = c ^ b;
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    end
`else
    r = c + b;
`endif
    return r;
  endfunction

  // State, byte index, check register and transmit byte register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      chk   <= '0;
      tx_q  <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      chk   <= chk_d;
      tx_q  <= tx_d;
    end
  end

  // Next-state logic: byte selection in LOAD, payload capture in PAY_WAIT,
  // and the txBusy rise/fall handshake with the UART.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    chk_d   = chk;
    tx_d    = tx_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          idx_d   = '0;
          chk_d   = '0;
        end
      end
      LOAD: begin
        state_d = SEND;
        if (idx == 17'd0) begin
          tx_d = SYNC0;
        end else if (idx == 17'd1) begin
          tx_d = SYNC1;
        end else if (idx == 17'd2) begin
          tx_d = LEN16[15:8];
        end else if (idx == 17'd3) begin
          tx_d = LEN16[7:0];
        end else if (idx < CHK_IDX) begin
          state_d = PAY_WAIT;
        end else if (idx == CHK_IDX) begin
          tx_d = chk;
        end else begin
          state_d = DONE;
        end
      end
      PAY_WAIT: begin
        if (in_valid) begin
          tx_d    = in_data;
          chk_d   = chk_update(chk, in_data);
          state_d = SEND;
        end
      end
      SEND: begin
        if (txBusy) begin
          state_d = WAIT_SEND;
        end
      end
      WAIT_SEND: begin
        if (!txBusy) begin
          idx_d   = idx + 17'd1;
          state_d = LOAD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the state; tx_in reads zero while idle.
  always_comb begin
    txEn       = (state != IDLE);
    frame_busy = (state != IDLE);
    txStart    = (state == SEND);
    in_ready   = (state == PAY_WAIT);
    frame_done = (state == DONE);
    tx_in      = (state == IDLE) ? '0 : tx_q;
  end

endmodule
